// File: rtl/alu_control_if.sv
//------------------------------------------------------------------------------
// alu_control_if
// Decode request/response bundle between an instruction source and alu_control.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_control_if;
    logic [3:0] Opcode;
    logic [2:0] Func;
    logic       in_valid;
    logic [2:0] ALUOp;
    logic       out_valid;
    logic       illegal;

    modport master (
        output Opcode,
        output Func,
        output in_valid,
        input  ALUOp,
        input  out_valid,
        input  illegal
    );

    modport slave (
        input  Opcode,
        input  Func,
        input  in_valid,
        output ALUOp,
        output out_valid,
        output illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_control.sv
//------------------------------------------------------------------------------
// alu_control
// Registered opcode/function decoder producing the ALU operation select.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_control (
    input  wire          clk,
    input  wire          rst_n,
    alu_control_if.slave bus
);

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b100;
    localparam logic [2:0] c_ALU_SLL = 3'b101;
    localparam logic [2:0] c_ALU_SRL = 3'b110;

    localparam logic [3:0] c_OP_RTYPE = 4'b0000;
    localparam logic [3:0] c_OP_ADDI  = 4'b0001;
    localparam logic [3:0] c_OP_ANDI  = 4'b0010;
    localparam logic [3:0] c_OP_ORI   = 4'b0011;
    localparam logic [3:0] c_OP_LW    = 4'b0100;
    localparam logic [3:0] c_OP_SW    = 4'b0101;
    localparam logic [3:0] c_OP_BEQ   = 4'b0110;
    localparam logic [3:0] c_OP_BNE   = 4'b0111;
    localparam logic [3:0] c_OP_SLTI  = 4'b1000;
    localparam logic [3:0] c_OP_LUI   = 4'b1001;

    logic [2:0] w_dec_op;
    logic       w_dec_illegal;

    logic [2:0] aluop_q,     aluop_d;
    logic       illegal_q,   illegal_d;
    logic       out_valid_q, out_valid_d;

    // Illegal combinations fall back to ADD so downstream never sees the reserved code.
    always_comb begin
        w_dec_op      = c_ALU_ADD;
        w_dec_illegal = 1'b0;
        case (bus.Opcode)
            c_OP_RTYPE: begin
                case (bus.Func)
                    3'b000:  w_dec_op = c_ALU_ADD;
                    3'b001:  w_dec_op = c_ALU_SUB;
                    3'b010:  w_dec_op = c_ALU_AND;
                    3'b011:  w_dec_op = c_ALU_OR;
                    3'b100:  w_dec_op = c_ALU_SLT;
                    3'b101:  w_dec_op = c_ALU_SLL;
                    3'b110:  w_dec_op = c_ALU_SRL;
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            c_OP_ADDI: w_dec_op = c_ALU_ADD;
            c_OP_ANDI: w_dec_op = c_ALU_AND;
            c_OP_ORI:  w_dec_op = c_ALU_OR;
            c_OP_LW:   w_dec_op = c_ALU_ADD;
            c_OP_SW:   w_dec_op = c_ALU_ADD;
            c_OP_BEQ:  w_dec_op = c_ALU_SUB;
            c_OP_BNE:  w_dec_op = c_ALU_SUB;
            c_OP_SLTI: w_dec_op = c_ALU_SLT;
            c_OP_LUI:  w_dec_op = c_ALU_SLL;
            default:   w_dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        aluop_d     = aluop_q;
        illegal_d   = illegal_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            aluop_d     = w_dec_op;
            illegal_d   = w_dec_illegal;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluop_q     <= c_ALU_ADD;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            aluop_q     <= aluop_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.ALUOp     = aluop_q;
    assign bus.illegal   = illegal_q;
    assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_control.sv
//------------------------------------------------------------------------------
// tb_alu_control
// Directed self-checking bench for alu_control.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_control;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_control_if bus ();

    alu_control u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] op, input logic ill, input logic vld);
        chk({tag, ".ALUOp"},     {5'd0, bus.ALUOp},     {5'd0, op});
        chk({tag, ".illegal"},   {7'd0, bus.illegal},   {7'd0, ill});
        chk({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, vld});
    endtask

    // Drive away from the active edge, then sample just after it.
    task automatic apply(input logic [3:0] op, input logic [2:0] fn, input logic v);
        @(negedge clk);
        bus.Opcode   = op;
        bus.Func     = fn;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_r  [8];
    logic [2:0] exp_i  [9];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_r = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000};
        exp_i = '{3'b000, 3'b010, 3'b011, 3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b101};

        bus.Opcode   = 4'b0000;
        bus.Func     = 3'b000;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset_hold", 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;

        // R-type sweep
        for (int f = 0; f < 8; f++) begin
            apply(4'b0000, 3'(f), 1'b1);
            chk_out($sformatf("rtype_f%0d", f), exp_r[f], (f == 7), 1'b1);
        end

        // I-type sweep with Func held at 101
        for (int o = 1; o < 10; o++) begin
            apply(4'(o), 3'b101, 1'b1);
            chk_out($sformatf("itype_op%0d", o), exp_i[o-1], 1'b0, 1'b1);
        end

        // Undefined opcodes
        for (int o = 10; o < 16; o++) begin
            apply(4'(o), 3'b010, 1'b1);
            chk_out($sformatf("illop_%0d", o), 3'b000, 1'b1, 1'b1);
        end

        // Hold when in_valid is low
        apply(4'b0000, 3'b001, 1'b1);
        chk_out("hold_pre", 3'b001, 1'b0, 1'b1);
        apply(4'b0010, 3'b000, 1'b0);
        chk_out("hold_idle", 3'b001, 1'b0, 1'b0);
        apply(4'b0010, 3'b000, 1'b0);
        chk_out("hold_idle2", 3'b001, 1'b0, 1'b0);

        // Illegal flag held too, then cleared by a legal decode
        apply(4'b1100, 3'b000, 1'b1);
        apply(4'b0011, 3'b000, 1'b0);
        chk_out("hold_illegal", 3'b000, 1'b1, 1'b0);
        apply(4'b0011, 3'b000, 1'b1);
        chk_out("clear_illegal", 3'b011, 1'b0, 1'b1);

        // Back-to-back BEQ then ADDI
        apply(4'b0110, 3'b000, 1'b1);
        chk_out("b2b_beq", 3'b001, 1'b0, 1'b1);
        apply(4'b0001, 3'b000, 1'b1);
        chk_out("b2b_addi", 3'b000, 1'b0, 1'b1);

        // Asynchronous reset between edges
        apply(4'b0000, 3'b110, 1'b1);
        chk_out("pre_async", 3'b110, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_out("rst_with_valid", 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_out("first_after_rst", 3'b110, 1'b0, 1'b1);

        // Reset mid-stream discards the in-flight decode
        @(negedge clk);
        bus.Opcode = 4'b1000;
        bus.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_out("midstream_rst", 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_out("idle_after_rst", 3'b000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
